// File: rtl/ad4008_pkg.sv
// Shared types and default frame constants for the AD4008 read path.
package ad4008_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READ    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int AD4008_WIDTH       = 16;
    localparam int AD4008_CONV_CYCLES = 30;

endpackage

// File: rtl/ad4008_sck_gen.sv
// Serial clock generator for the AD4008 read: SCLK_DIV cycles low, SCLK_DIV high per bit.
// Counters hold at zero while disabled so every READ starts with a full low half-period.
module ad4008_sck_gen
    import ad4008_pkg::*;
#(
    parameter int ADC_WIDTH = AD4008_WIDTH,
    parameter int SCLK_DIV  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic fall,
    output logic last_bit
);

    localparam int HW = $clog2(SCLK_DIV + 1);
    localparam int BW = $clog2(ADC_WIDTH + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(ADC_WIDTH - 1);

    logic [HW-1:0] half_cnt_r;
    logic [BW-1:0] bit_cnt_r;
    logic          sck_r;
    logic          half_end_s;

    // Strobes: fall marks the edge that drives sck 1->0 (the sample point).
    always_comb begin
        half_end_s = (half_cnt_r == HALF_LAST);
        fall       = en && half_end_s && sck_r;
        last_bit   = fall && (bit_cnt_r == BIT_LAST);
    end

    // Half-period counter, sck level and completed-bit counter.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            half_cnt_r <= HW'(0);
            bit_cnt_r  <= BW'(0);
            sck_r      <= 1'b0;
        end else if (half_end_s) begin
            half_cnt_r <= HW'(0);
            sck_r      <= ~sck_r;
            if (sck_r) begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end
        end else begin
            half_cnt_r <= half_cnt_r + HW'(1);
        end
    end

    assign sck = sck_r;

endmodule

// File: rtl/ad4008_read.sv
// AD4008 16-bit SAR ADC reader (3-wire CS mode): convert, shift in MSB-first, strobe result.
// Build option: define ADC_READ_FREE_RUN_EN to convert continuously and ignore start.
module ad4008_read
    import ad4008_pkg::*;
#(
    parameter int ADC_WIDTH   = AD4008_WIDTH,
    parameter int CONV_CYCLES = AD4008_CONV_CYCLES,
    parameter int SCLK_DIV    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sdo,
    output logic                 cnv,
    output logic                 sck,
    output logic                 busy,
    output logic [ADC_WIDTH-1:0] data_out,
    output logic                 data_valid
);

    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

    state_t                 state_r;
    state_t                 state_s;
    logic [CW-1:0]          conv_cnt_r;
    logic [ADC_WIDTH-1:0]   shift_r;
    logic [ADC_WIDTH-1:0]   shift_s;
    logic                   go_s;
    logic                   sck_en_s;
    logic                   sck_fall_s;
    logic                   last_bit_s;
    logic                   cnv_r, busy_r, data_valid_r;
    logic                   cnv_s, busy_s, data_valid_s;
    logic [ADC_WIDTH-1:0]   data_out_r;
    logic [ADC_WIDTH-1:0]   data_out_s;

`ifdef ADC_READ_FREE_RUN_EN
    logic unused_start_s;
    assign unused_start_s = start;
    assign go_s           = 1'b1;
`else
    assign go_s = start;
`endif

    assign sck_en_s = (state_r == READ);
    assign shift_s  = {shift_r[ADC_WIDTH-2:0], sdo};

    ad4008_sck_gen #(
        .ADC_WIDTH (ADC_WIDTH),
        .SCLK_DIV  (SCLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (sck_en_s),
        .sck      (sck),
        .fall     (sck_fall_s),
        .last_bit (last_bit_s)
    );

    // State register, conversion counter and sample shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            conv_cnt_r <= CW'(0);
            shift_r    <= {ADC_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == CONVERT && state_s == CONVERT) begin
                conv_cnt_r <= conv_cnt_r + CW'(1);
            end else begin
                conv_cnt_r <= CW'(0);
            end
            if (sck_fall_s) begin
                shift_r <= shift_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (go_s) state_s = CONVERT; else state_s = IDLE;
            CONVERT: if (conv_cnt_r == CONV_LAST) state_s = READ; else state_s = CONVERT;
            READ:    if (last_bit_s) state_s = DONE; else state_s = READ;
`ifdef ADC_READ_FREE_RUN_EN
            DONE:    state_s = CONVERT;
`else
            DONE:    state_s = IDLE;
`endif
            default: state_s = IDLE;
        endcase
    end

    // Output values for the coming cycle; the final bit enters data_out on the DONE edge.
    always_comb begin
        cnv_s        = (state_s == CONVERT);
        busy_s       = (state_s != IDLE);
        data_valid_s = (state_s == DONE);
        if (state_s == DONE) begin
            data_out_s = shift_s;
        end else begin
            data_out_s = data_out_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnv_r        <= 1'b0;
            busy_r       <= 1'b0;
            data_valid_r <= 1'b0;
            data_out_r   <= {ADC_WIDTH{1'b0}};
        end else begin
            cnv_r        <= cnv_s;
            busy_r       <= busy_s;
            data_valid_r <= data_valid_s;
            data_out_r   <= data_out_s;
        end
    end

    assign cnv        = cnv_r;
    assign busy       = busy_r;
    assign data_valid = data_valid_r;
    assign data_out   = data_out_r;

endmodule

// File: tb/tb_ad4008_read.sv
// Randomized scoreboard bench for ad4008_read with an AD4008 behavioural model.
module tb_ad4008_read;

    localparam int W   = 16;
    localparam int CC  = 30;
    localparam int SD  = 2;
    localparam int LAT = 1 + CC + 2 * W * SD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          sdo = 1'b0;
    logic          cnv;
    logic          sck;
    logic          busy;
    logic [W-1:0]  data_out;
    logic          data_valid;

    always #5 clk = ~clk;

    ad4008_read dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sdo        (sdo),
        .cnv        (cnv),
        .sck        (sck),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    typedef struct {int cyc; logic [W-1:0] val;} exp_t;
    typedef struct {logic [3:0] pins; logic [W-1:0] dout;} pin_t;

    exp_t          sb_q[$];
    logic [W-1:0]  adc_q[$];
    pin_t          exp_pins[int];

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            acc = -1000;
    int            free_at = 0;
    logic [W-1:0]  frame_val = '0;
    logic [W-1:0]  dout_model = '0;
    logic          end_check = 1'b0;
    logic          end_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // AD4008 model: new sample per conversion, MSB after cnv falls, next bit after each sck fall.
    logic [W-1:0]  adc_cur = '0;
    int            adc_bit = 0;
    always @(posedge cnv) begin
        if (adc_q.size() > 0) adc_cur = adc_q.pop_front();
        else adc_cur = 16'hDEAD;
    end
    always @(negedge cnv) begin
        adc_bit = W - 1;
        #1 sdo = adc_cur[adc_bit];
    end
    always @(negedge sck) begin
        if (adc_bit > 0) adc_bit = adc_bit - 1;
        #1 sdo = adc_cur[adc_bit];
    end

    // Drive one cycle of inputs and predict the pins for the following cycle.
    task automatic step(input logic s, input logic r, input logic [W-1:0] v);
        int   c;
        int   o;
        pin_t e;
        c     = cyc;
        start = s;
        rst   = r;
        if (r) begin
            if (sb_q.size() > 0 && sb_q[$].cyc > c) void'(sb_q.pop_back());
            acc        = -1000;
            free_at    = c + 1;
            dout_model = '0;
        end else if (s && c >= free_at) begin
            acc       = c;
            free_at   = c + LAT + 1;
            frame_val = v;
            sb_q.push_back('{c + LAT, v});
            adc_q.push_back(v);
        end
        o      = c + 1 - acc;
        e.pins = 4'b0000;
        if (!r && o >= 1 && o <= LAT) begin
            e.pins[3] = (o <= CC);
            if (o > CC && o < LAT) e.pins[2] = (((o - CC - 1) / SD) % 2) == 1;
            e.pins[1] = 1'b1;
            e.pins[0] = (o == LAT);
            if (o == LAT) dout_model = frame_val;
        end
        e.dout = dout_model;
        exp_pins[c + 1] = e;
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle pin check plus scoreboard pop on every data_valid.
    always @(negedge clk) begin
        pin_t e;
        exp_t x;
        if (exp_pins.exists(cyc)) begin
            e = exp_pins[cyc];
            n_cmp++;
            if ({cnv, sck, busy, data_valid} !== e.pins || data_out !== e.dout) begin
                n_err++;
                $display("FAIL pins cyc=%0d: cnv/sck/busy/valid=%b data_out=%h, expected %b %h",
                         cyc, {cnv, sck, busy, data_valid}, data_out, e.pins, e.dout);
            end
            exp_pins.delete(cyc);
        end
        if (data_valid === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL result cyc=%0d: unexpected data_valid data_out=%h, expected none",
                         cyc, data_out);
            end else begin
                x = sb_q.pop_front();
                if (x.cyc != cyc || data_out !== x.val) begin
                    n_err++;
                    $display("FAIL result: got cyc=%0d data=%h, expected cyc=%0d data=%h",
                             cyc, data_out, x.cyc, x.val);
                end
            end
        end
        if (end_check && !end_done) begin
            end_done = 1'b1;
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_err++;
                $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
            end
        end
    end

    initial begin
        logic [W-1:0] rv;
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b1, 16'h0000);
        repeat (5) step(1'b0, 1'b0, 16'h0000);

        step(1'b1, 1'b0, 16'hA5C3);
        repeat (100) step(1'b0, 1'b0, 16'h0000);

        // Second start at offset 40 lands mid-frame and must be dropped.
        step(1'b1, 1'b0, 16'h5A3C);
        repeat (39) step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'hBEEF);
        repeat (60) step(1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0, (i == 0) ? 16'h0000 : 16'hFFFF);
        repeat (100) step(1'b0, 1'b0, 16'h0000);

        step(1'b1, 1'b0, 16'hCAFE);
        repeat (49) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0000);
        repeat (5) step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h1234);
        repeat (100) step(1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            rv = 16'($urandom);
            step($urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0, rv);
        end
        repeat (100) step(1'b0, 1'b0, 16'h0000);

        end_check = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
